// File: rtl/instr_enc_defs.sv
// -----------------------------------------------------------------------------
// instr_enc_defs
//   Shared definitions for the RV32I instruction encoder: the instruction
//   format codes driven on in_fmt, the error codes reported on err_code, and
//   the major opcodes used by the pipeline's decoder.
// -----------------------------------------------------------------------------
package instr_enc_defs;

  // Instruction format selector (value of in_fmt).
  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_I_SHIFT = 3'd2,
    FMT_S       = 3'd3,
    FMT_B       = 3'd4,
    FMT_U       = 3'd5,
    FMT_J       = 3'd6,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  // Error classification for a rejected bundle.
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_FMT   = 2'd3
  } err_e;

  // Major opcodes shared with the decoder.
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] I_TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE      = 7'b0100011;
  localparam logic [6:0] B_TYPE      = 7'b1100011;
  localparam logic [6:0] J_JAL       = 7'b1101111;
  localparam logic [6:0] I_JALR      = 7'b1100111;
  localparam logic [6:0] U_AUIPC     = 7'b0010111;
  localparam logic [6:0] U_LUI       = 7'b0110111;
  localparam logic [6:0] R_TYPE      = 7'b0110011;

endpackage

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
//   Purely combinational field packer. Places the instruction fields into the
//   RV32I bit layout selected by i_fmt and classifies the immediate.
//   Ports:
//     i_fmt, i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm : fields
//     o_data     : packed 32-bit instruction word (0 for an illegal format)
//     o_err_code : ERR_NONE, or why the bundle cannot be encoded
// -----------------------------------------------------------------------------
module instr_pack
  import instr_enc_defs::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_data,
  output err_e        o_err_code
);

  logic signed [31:0] w_imm_s;
  assign w_imm_s = $signed(i_imm);

  // A value that is both out of range and odd reports the range error.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    o_data     = '0;
    o_err_code = ERR_NONE;
    case (fmt_e'(i_fmt))
      FMT_R: begin
        o_data = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      FMT_I: begin
        o_data = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        if (w_imm_s < -32'sd2048 || w_imm_s > 32'sd2047) o_err_code = ERR_RANGE;
      end
      FMT_I_SHIFT: begin
        o_data = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
        if (w_imm_s < 32'sd0 || w_imm_s > 32'sd31) o_err_code = ERR_RANGE;
      end
      FMT_S: begin
        o_data = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        if (w_imm_s < -32'sd2048 || w_imm_s > 32'sd2047) o_err_code = ERR_RANGE;
      end
      FMT_B: begin
        o_data = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                  i_imm[4:1], i_imm[11], i_opcode};
        if (w_imm_s < -32'sd4096 || w_imm_s > 32'sd4094) o_err_code = ERR_RANGE;
        else if (i_imm[0])                                o_err_code = ERR_ALIGN;
      end
      FMT_U: begin
        o_data = {i_imm[31:12], i_rd, i_opcode};
        if (i_imm[11:0] != 12'd0) o_err_code = ERR_ALIGN;
      end
      FMT_J: begin
        o_data = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        if (w_imm_s < -32'sd1048576 || w_imm_s > 32'sd1048574) o_err_code = ERR_RANGE;
        else if (i_imm[0])                                      o_err_code = ERR_ALIGN;
      end
      FMT_ILLEGAL: begin
        o_err_code = ERR_FMT;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Packs RV32I instruction fields into 32-bit words and emits each word with
//   an auto-incrementing byte address through a single-entry, full-throughput
//   valid/ready register stage. The first encoding error since reset or flush
//   is captured in sticky err/err_code/err_addr.
//   Ports:
//     clk, rst (sync, active high), flush
//     in_valid/in_ready + in_fmt, in_opcode, in_funct3, in_funct7, in_rd,
//       in_rs1, in_rs2, in_imm : input field bundle
//     out_valid/out_ready + out_addr, out_data : encoded word stream
//     err, err_code, err_addr : sticky first-error record
//     word_count : words emitted since reset/flush, saturating
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_enc_defs::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       word_count
);

  logic [31:0]       w_pack_data;
  err_e              w_pack_err;
  logic              w_accept;
  logic              w_beat;
  logic              w_ok;
  logic [ADDR_W-1:0] w_next_inc;
  logic [ADDR_W-1:0] w_load_addr;

  logic              r_out_valid;
  logic [31:0]       r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic              r_err;
  err_e              r_err_code;
  logic [ADDR_W-1:0] r_err_addr;
  logic [15:0]       r_word_count;

  instr_pack u_pack (
    .i_fmt      (in_fmt),
    .i_opcode   (in_opcode),
    .i_funct3   (in_funct3),
    .i_funct7   (in_funct7),
    .i_rd       (in_rd),
    .i_rs1      (in_rs1),
    .i_rs2      (in_rs2),
    .i_imm      (in_imm),
    .o_data     (w_pack_data),
    .o_err_code (w_pack_err)
  );

  // The stage can take a new bundle whenever the held word is leaving this
  // cycle, so continuous flow has no bubble.
  assign in_ready   = !flush && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_beat     = r_out_valid && out_ready;
  assign w_ok       = (w_pack_err == ERR_NONE);
  assign w_next_inc = r_next_addr + ADDR_W'(4);
  // A word loaded in the same cycle as a beat takes the post-increment address.
  assign w_load_addr = w_beat ? w_next_inc : r_next_addr;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_addr   <= BASE_ADDR;
      r_next_addr  <= BASE_ADDR;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_addr   <= '0;
      r_word_count <= '0;
    end else if (flush) begin
      // The held word is dropped; in_ready is low so nothing loads.
      r_out_valid  <= 1'b0;
      r_next_addr  <= BASE_ADDR;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_addr   <= '0;
      r_word_count <= '0;
    end else begin
      if (w_beat) begin
        r_next_addr <= w_next_inc;
        if (r_word_count != 16'hFFFF) r_word_count <= r_word_count + 16'd1;
      end

      if (w_accept && w_ok) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pack_data;
        r_out_addr  <= w_load_addr;
      end else if (w_beat) begin
        r_out_valid <= 1'b0;
      end

      // Failing bundles are consumed silently; only the first is recorded.
      if (w_accept && !w_ok && !r_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_pack_err;
        r_err_addr <= w_load_addr;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_addr   = r_out_addr;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign err_addr   = r_err_addr;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Self-checking bench for instr_encoder: directed vectors with literal
//   expected words, then a randomized stream compared against a cycle-level
//   reference model that encodes with shift/mask arithmetic.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_data;
  logic [31:0] out_addr, err_addr;
  logic [1:0]  err_code;
  logic [15:0] word_count;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .err        (err),
    .err_code   (err_code),
    .err_addr   (err_addr),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  logic        m_valid, m_err;
  logic [31:0] m_data, m_addr, m_next, m_eaddr;
  logic [1:0]  m_code;
  logic [15:0] m_cnt;

  // Encoding by the instruction-set rules, using shifts and masks.
  function automatic void ref_enc(input logic [2:0] f, input logic [6:0] op,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] u,
                                  output logic [31:0] w, output logic [1:0] code);
    int s;
    logic [31:0] base;
    s    = int'(u);
    base = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
    w    = 32'd0;
    code = 2'd0;
    case (f)
      3'd0: w = base | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
      3'd1: begin
        w = base | (32'(rd) << 7) | ((u & 32'hFFF) << 20);
        if (s < -2048 || s > 2047) code = 2'd1;
      end
      3'd2: begin
        w = base | (32'(rd) << 7) | ((u & 32'h1F) << 20) | (32'(f7) << 25);
        if (s < 0 || s > 31) code = 2'd1;
      end
      3'd3: begin
        w = base | ((u & 32'h1F) << 7) | (32'(rs2) << 20) | (((u >> 5) & 32'h7F) << 25);
        if (s < -2048 || s > 2047) code = 2'd1;
      end
      3'd4: begin
        w = base | (((u >> 11) & 32'h1) << 7) | (((u >> 1) & 32'hF) << 8)
                 | (32'(rs2) << 20) | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 32'h1) << 31);
        if (s < -4096 || s > 4094) code = 2'd1;
        else if (s % 2 != 0) code = 2'd2;
      end
      3'd5: begin
        w = 32'(op) | (32'(rd) << 7) | (u & 32'hFFFF_F000);
        if ((u & 32'hFFF) != 0) code = 2'd2;
      end
      3'd6: begin
        w = 32'(op) | (32'(rd) << 7) | (u & 32'h000F_F000) | (((u >> 11) & 32'h1) << 20)
                    | (((u >> 1) & 32'h3FF) << 21) | (((u >> 20) & 32'h1) << 31);
        if (s < -1048576 || s > 1048574) code = 2'd1;
        else if (s % 2 != 0) code = 2'd2;
      end
      default: code = 2'd3;
    endcase
  endfunction

  task automatic set_b(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // One clock: drive controls, check in_ready, advance model, check outputs.
  task automatic cycle(input logic r, input logic fl, input logic iv, input logic orr);
    logic [31:0] w;
    logic [1:0]  c;
    logic        exp_rdy, beat, acc;
    rst = r; flush = fl; in_valid = iv; out_ready = orr;
    ref_enc(in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, w, c);
    exp_rdy = !fl && (!m_valid || orr);
    #1;
    if (!r) check("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = 0; m_addr = BASE; m_next = BASE;
      m_err = 0; m_code = 0; m_eaddr = 0; m_cnt = 0;
    end else if (fl) begin
      m_valid = 0; m_next = BASE; m_err = 0; m_code = 0; m_eaddr = 0; m_cnt = 0;
    end else begin
      beat = m_valid && orr;
      acc  = iv && exp_rdy;
      if (beat) begin
        m_next = m_next + 32'd4;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (acc && c == 2'd0) begin
        m_valid = 1; m_data = w; m_addr = m_next;
      end else if (beat) begin
        m_valid = 0;
      end
      if (acc && c != 2'd0 && !m_err) begin
        m_err = 1; m_code = c; m_eaddr = m_next;
      end
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check("out_data", 64'(out_data), 64'(m_data));
      check("out_addr", 64'(out_addr), 64'(m_addr));
    end
    check("err", 64'(err), 64'(m_err));
    check("err_code", 64'(err_code), 64'(m_code));
    check("err_addr", 64'(err_addr), 64'(m_eaddr));
    check("word_count", 64'(word_count), 64'(m_cnt));
    @(negedge clk);
  endtask

  task automatic rand_bundle();
    logic [2:0] f;
    int         v;
    f = ($urandom_range(0, 15) < 15) ? 3'($urandom_range(0, 6)) : 3'd7;
    case (f)
      3'd1, 3'd3: v = int'($urandom_range(0, 4095)) - 2048;
      3'd2:       v = int'($urandom_range(0, 31));
      3'd4:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      3'd5:       v = int'($urandom & 32'hFFFF_F000);
      3'd6:       v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      default:    v = int'($urandom);
    endcase
    if ($urandom_range(0, 9) == 0) v = int'($urandom);
    set_b(f, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom), 32'(v));
  endtask

  initial begin
    set_b(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_addr", 64'(out_addr), 64'(BASE));

    // Directed words streamed with out_ready held high.
    set_b(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    cycle(0, 0, 1, 1);
    check("I_word", 64'(out_data), 64'h0050_0093);
    check("I_addr", 64'(out_addr), 64'(BASE));
    set_b(3'd3, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    cycle(0, 0, 1, 1);
    check("S_word", 64'(out_data), 64'h0020_A423);
    check("S_addr", 64'(out_addr), 64'(BASE + 32'd4));
    set_b(3'd4, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4);
    cycle(0, 0, 1, 1);
    check("B_word", 64'(out_data), 64'hFE00_0EE3);
    check("B_addr", 64'(out_addr), 64'(BASE + 32'd8));
    set_b(3'd6, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    cycle(0, 0, 1, 1);
    check("J_word", 64'(out_data), 64'h0010_00EF);
    set_b(3'd5, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    cycle(0, 0, 1, 1);
    check("U_word", 64'(out_data), 64'h1234_52B7);
    set_b(3'd2, 7'b0010011, 3'b101, 7'b0100000, 5'd3, 5'd3, 5'd0, 32'd4);
    cycle(0, 0, 1, 1);
    check("ISH_word", 64'(out_data), 64'h4041_D193);
    check("ISH_addr", 64'(out_addr), 64'(BASE + 32'd20));

    // Backpressure: held word stays put, then drains and the next one loads.
    set_b(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
    check("hold_word", 64'(out_data), 64'h4041_D193);
    cycle(0, 0, 1, 1);
    check("after_hold_word", 64'(out_data), 64'h0070_0113);
    check("after_hold_addr", 64'(out_addr), 64'(BASE + 32'd24));
    check("after_hold_count", 64'(word_count), 64'd6);

    // First error recorded; a later one is ignored; address is reused.
    set_b(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    cycle(0, 0, 1, 1);
    check("err_flag", 64'(err), 64'd1);
    check("err_code_range", 64'(err_code), 64'd1);
    check("err_addr_val", 64'(err_addr), 64'(BASE + 32'd28));
    set_b(3'd4, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd7);
    cycle(0, 0, 1, 1);
    check("err_code_sticky", 64'(err_code), 64'd1);
    set_b(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    cycle(0, 0, 1, 1);
    check("post_err_word", 64'(out_data), 64'h0010_0093);
    check("post_err_addr", 64'(out_addr), 64'(BASE + 32'd28));

    // Flush with a word held and an error recorded.
    cycle(0, 1, 1, 0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_err", 64'(err), 64'd0);
    check("flush_count", 64'(word_count), 64'd0);
    set_b(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    cycle(0, 0, 1, 1);
    check("flush_next_addr", 64'(out_addr), 64'(BASE));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rand_bundle();
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    // Reset mid-stream.
    set_b(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'h0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_count", 64'(word_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
